// File: rtl/timer_pkg.sv
// Shared register map for the timer block: offsets, CONTROL bit positions and bus widths.
// Also used by the counter wrapper and by the generated software headers.
package timer_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;

  localparam logic [ADDR_W-1:0] OFF_LOAD_COUNT     = 8'h00;
  localparam logic [ADDR_W-1:0] OFF_CURRENT_VALUE  = 8'h04;
  localparam logic [ADDR_W-1:0] OFF_CONTROL        = 8'h08;
  localparam logic [ADDR_W-1:0] OFF_EOI            = 8'h0C;
  localparam logic [ADDR_W-1:0] OFF_INT_STATUS     = 8'h10;
  localparam logic [ADDR_W-1:0] OFF_RAW_INT_STATUS = 8'h14;

  localparam int CTRL_W          = 3;
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_MODE_BIT   = 1;
  localparam int CTRL_MASK_BIT   = 2;

  function automatic logic is_read_only(input logic [ADDR_W-1:0] addr);
    return (addr == OFF_CURRENT_VALUE) || (addr == OFF_EOI) ||
           (addr == OFF_INT_STATUS)    || (addr == OFF_RAW_INT_STATUS);
  endfunction

  // Misaligned, beyond the map, or a write aimed at a read-only register.
  function automatic logic access_error(input logic [ADDR_W-1:0] addr, input logic write);
    return (addr[1:0] != 2'b00) || (addr > OFF_RAW_INT_STATUS) ||
           (write && is_read_only(addr));
  endfunction

endpackage

// File: rtl/timer_regif.sv
// APB3 register interface for the timer: configuration registers out to the counter,
// interrupt edge capture with EOI clear, and a registered masked interrupt line.
module timer_regif
  import timer_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              timer_enable,
  output logic              timer_mode,
  output logic [DATA_W-1:0] timer_load_count,
  input  logic [DATA_W-1:0] timer_current_value,
  input  logic              timer_interrupt,
  output logic              irq
);

  logic [DATA_W-1:0] load_q, load_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              raw_q, raw_d;
  logic              int_prev_q;
  logic              irq_q, irq_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              pslverr_q, pslverr_d;

  logic              setup_ph, access_ph, xfer_err, wr_en, eoi_clr, int_rise, int_status;
  logic [DATA_W-1:0] rd_val;

  assign setup_ph   = psel & ~penable;
  assign access_ph  = psel & penable;
  assign xfer_err   = access_error(paddr, pwrite);
  assign wr_en      = access_ph & pwrite & ~xfer_err;
  assign eoi_clr    = access_ph & ~pwrite & ~xfer_err & (paddr == OFF_EOI);
  assign int_rise   = timer_interrupt & ~int_prev_q;
  assign int_status = raw_q & ~ctrl_q[CTRL_MASK_BIT];

  always_comb begin
    rd_val = '0;
    case (paddr)
      OFF_LOAD_COUNT:     rd_val = load_q;
      OFF_CURRENT_VALUE:  rd_val = timer_current_value;
      OFF_CONTROL:        rd_val = {{(DATA_W-CTRL_W){1'b0}}, ctrl_q};
      OFF_INT_STATUS:     rd_val = {{(DATA_W-1){1'b0}}, int_status};
      OFF_RAW_INT_STATUS: rd_val = {{(DATA_W-1){1'b0}}, raw_q};
      default:            rd_val = '0;
    endcase
  end

  always_comb begin
    load_d = load_q;
    ctrl_d = ctrl_q;
    if (wr_en && (paddr == OFF_LOAD_COUNT)) load_d = pwdata;
    if (wr_en && (paddr == OFF_CONTROL))    ctrl_d = pwdata[CTRL_W-1:0];

    // A new interrupt edge wins over a simultaneous EOI so no event is lost.
    raw_d = raw_q;
    if (int_rise)     raw_d = 1'b1;
    else if (eoi_clr) raw_d = 1'b0;

    irq_d = int_status;

    // Read data and error flag are captured in setup and held through access.
    prdata_d  = prdata_q;
    pslverr_d = 1'b0;
    if (setup_ph) begin
      prdata_d  = xfer_err ? '0 : rd_val;
      pslverr_d = xfer_err;
    end else if (access_ph) begin
      pslverr_d = pslverr_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      load_q     <= '0;
      ctrl_q     <= '0;
      raw_q      <= 1'b0;
      int_prev_q <= 1'b0;
      irq_q      <= 1'b0;
      prdata_q   <= '0;
      pslverr_q  <= 1'b0;
    end else begin
      load_q     <= load_d;
      ctrl_q     <= ctrl_d;
      raw_q      <= raw_d;
      int_prev_q <= timer_interrupt;
      irq_q      <= irq_d;
      prdata_q   <= prdata_d;
      pslverr_q  <= pslverr_d;
    end
  end

  assign prdata           = prdata_q;
  assign pready           = 1'b1;
  assign pslverr          = pslverr_q & access_ph;
  assign timer_enable     = ctrl_q[CTRL_ENABLE_BIT];
  assign timer_mode       = ctrl_q[CTRL_MODE_BIT];
  assign timer_load_count = load_q;
  assign irq              = irq_q;

endmodule

// File: tb/tb_timer_regif.sv
// Self-checking bench for timer_regif: directed scenarios followed by random APB traffic
// checked against a simple register/pending-interrupt model.
module tb_timer_regif;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = 8'h00;
  logic [31:0] pwdata = 32'h0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        timer_enable;
  logic        timer_mode;
  logic [31:0] timer_load_count;
  logic [31:0] timer_current_value = 32'h0;
  logic        timer_interrupt = 1'b0;
  logic        irq;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_load = 32'h0;
  logic [2:0]  m_ctrl = 3'h0;
  logic        m_pend = 1'b0;

  timer_regif dut (
    .clk                 (clk),
    .rstn                (rstn),
    .psel                (psel),
    .penable             (penable),
    .pwrite              (pwrite),
    .paddr               (paddr),
    .pwdata              (pwdata),
    .prdata              (prdata),
    .pready              (pready),
    .pslverr             (pslverr),
    .timer_enable        (timer_enable),
    .timer_mode          (timer_mode),
    .timer_load_count    (timer_load_count),
    .timer_current_value (timer_current_value),
    .timer_interrupt     (timer_interrupt),
    .irq                 (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_err(input logic [7:0] a, input logic wr);
    logic ro;
    ro = (a == 8'h04) || (a == 8'h0C) || (a == 8'h10) || (a == 8'h14);
    return (a[1:0] != 2'b00) || (a > 8'h14) || (wr && ro);
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] a, input logic [31:0] cv);
    case (a)
      8'h00:   return m_load;
      8'h04:   return cv;
      8'h08:   return {29'h0, m_ctrl};
      8'h10:   return {31'h0, m_pend & ~m_ctrl[2]};
      8'h14:   return {31'h0, m_pend};
      default: return 32'h0;
    endcase
  endfunction

  // One APB transfer; coll raises timer_interrupt during the access cycle.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] wd, input logic coll);
    logic        exp_err;
    logic [31:0] exp_rd, rd;
    logic        err;
    timer_current_value = $urandom;
    exp_err = model_err(a, wr);
    exp_rd  = exp_err ? 32'h0 : model_read(a, timer_current_value);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    #1;
    chk("pslverr_setup", {31'h0, pslverr}, 32'h0);
    cyc();
    penable = 1'b1;
    if (coll) timer_interrupt = 1'b1;
    #1;
    rd = prdata; err = pslverr;
    chk("pready", {31'h0, pready}, 32'h1);
    chk($sformatf("pslverr_%02h", a), {31'h0, err}, {31'h0, exp_err});
    if (!wr) chk($sformatf("prdata_%02h", a), rd, exp_rd);
    @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    if (coll) timer_interrupt = 1'b0;
    if (wr && !exp_err && a == 8'h00) m_load = wd;
    if (wr && !exp_err && a == 8'h08) m_ctrl = wd[2:0];
    if (!wr && !exp_err && a == 8'h0C) m_pend = 1'b0;
    if (coll) m_pend = 1'b1;
    $display("apb %s addr=%02h wdata=%08h rdata=%08h err=%0b coll=%0b",
             wr ? "wr" : "rd", a, wd, rd, err, coll);
  endtask

  task automatic pulse_int();
    timer_interrupt = 1'b1;
    cyc();
    timer_interrupt = 1'b0;
    m_pend = 1'b1;
    $display("int pulse");
  endtask

  // Config outputs are valid right after the access edge; irq one cycle later.
  task automatic settle();
    chk("timer_load_count", timer_load_count, m_load);
    chk("timer_enable", {31'h0, timer_enable}, {31'h0, m_ctrl[0]});
    chk("timer_mode", {31'h0, timer_mode}, {31'h0, m_ctrl[1]});
    cyc();
    chk("irq", {31'h0, irq}, {31'h0, m_pend & ~m_ctrl[2]});
  endtask

  initial begin
    logic [7:0] bad_addrs [7];
    bad_addrs = '{8'h02, 8'h18, 8'h15, 8'h40, 8'hFF, 8'h01, 8'h1C};

    // Reset state
    cyc();
    cyc();
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pready", {31'h0, pready}, 32'h1);
    chk("rst_pslverr", {31'h0, pslverr}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rstn = 1'b1;
    cyc();
    xfer(1'b0, 8'h08, 32'h0, 1'b0); settle();
    xfer(1'b0, 8'h00, 32'h0, 1'b0); settle();

    // Configuration
    xfer(1'b1, 8'h00, 32'h10, 1'b0); settle();
    xfer(1'b1, 8'h08, 32'h3, 1'b0); settle();
    xfer(1'b0, 8'h04, 32'h0, 1'b0); settle();

    // Interrupt: status the cycle after the edge, irq one cycle later
    pulse_int();
    chk("irq_lag", {31'h0, irq}, 32'h0);
    cyc();
    chk("irq_set", {31'h0, irq}, 32'h1);
    xfer(1'b0, 8'h14, 32'h0, 1'b0); settle();
    xfer(1'b0, 8'h0C, 32'h0, 1'b0);
    chk("irq_eoi_lag", {31'h0, irq}, 32'h1);
    settle();

    // Collision of new edge with EOI clear
    pulse_int(); settle();
    xfer(1'b0, 8'h0C, 32'h0, 1'b1); settle();
    xfer(1'b0, 8'h14, 32'h0, 1'b0); settle();
    xfer(1'b0, 8'h0C, 32'h0, 1'b0); settle();

    // Level held high: only the rising edge sets status
    timer_interrupt = 1'b1; m_pend = 1'b1;
    cyc(); cyc();
    xfer(1'b0, 8'h0C, 32'h0, 1'b0);
    cyc();
    timer_interrupt = 1'b0;
    settle();
    xfer(1'b0, 8'h14, 32'h0, 1'b0); settle();

    // Masking; disabling the timer keeps status
    xfer(1'b1, 8'h08, 32'h5, 1'b0); settle();
    pulse_int(); settle();
    xfer(1'b0, 8'h14, 32'h0, 1'b0); settle();
    xfer(1'b0, 8'h10, 32'h0, 1'b0); settle();
    xfer(1'b1, 8'h08, 32'h1, 1'b0);
    chk("irq_unmask_lag", {31'h0, irq}, 32'h0);
    settle();
    xfer(1'b1, 8'h08, 32'h0, 1'b0); settle();
    xfer(1'b0, 8'h14, 32'h0, 1'b0); settle();
    xfer(1'b0, 8'h0C, 32'h0, 1'b0); settle();

    // Error transfers leave state untouched
    xfer(1'b1, 8'h04, 32'hFFFF_FFFF, 1'b0); settle();
    xfer(1'b0, 8'h18, 32'h0, 1'b0); settle();
    xfer(1'b1, 8'h02, 32'hA5A5_A5A5, 1'b0); settle();
    xfer(1'b0, 8'h02, 32'h0, 1'b0); settle();
    xfer(1'b1, 8'h0A, 32'h7, 1'b0); settle();
    xfer(1'b0, 8'h00, 32'h0, 1'b0); settle();
    xfer(1'b0, 8'h08, 32'h0, 1'b0); settle();

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      int op;
      logic [7:0] a;
      op = $urandom_range(0, 6);
      case (op)
        0: xfer(1'b1, 8'h00, $urandom, 1'b0);
        1: xfer(1'b1, 8'h08, $urandom, 1'b0);
        2: begin
          a = 8'($urandom_range(0, 5) * 4);
          xfer(1'b0, a, 32'h0, 1'b0);
        end
        3: pulse_int();
        4: xfer(1'b0, 8'h0C, 32'h0, ($urandom_range(0, 3) == 0));
        5: begin
          a = ($urandom_range(0, 1) == 0) ? bad_addrs[$urandom_range(0, 6)] : 8'($urandom);
          xfer($urandom_range(0, 1) == 1, a, $urandom, 1'b0);
        end
        default: cyc();
      endcase
      settle();
    end

    // Reset in the middle of a write access
    pulse_int(); settle();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'hDEAD_BEEF;
    cyc();
    penable = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_load", timer_load_count, 32'h0);
    chk("async_rst_irq", {31'h0, irq}, 32'h0);
    chk("async_rst_pslverr", {31'h0, pslverr}, 32'h0);
    cyc();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    cyc();
    rstn = 1'b1;
    m_load = 32'h0; m_ctrl = 3'h0; m_pend = 1'b0;
    $display("reset during access");
    cyc();
    xfer(1'b0, 8'h00, 32'h0, 1'b0); settle();
    xfer(1'b0, 8'h14, 32'h0, 1'b0); settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_regif.md
TIMER_REGIF -- requirements
Module: timer_regif

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state on rising edge.
REQ-002 SHALL have: rstn  in  1  asynchronous reset, active-low.
REQ-003 SHALL have: psel  in  1  APB3 select.
REQ-004 SHALL have: penable  in  1  APB3 access phase.
REQ-005 SHALL have: pwrite  in  1  1=write, 0=read.
REQ-006 SHALL have: paddr  in  8  byte address.
REQ-007 SHALL have: pwdata  in  32  write data.
REQ-008 SHALL have: prdata  out  32  read data.
REQ-009 SHALL have: pready  out  1  always 1; no wait states.
REQ-010 SHALL have: pslverr  out  1  transfer error.
REQ-011 SHALL have: timer_enable, timer_mode  out  1 each  to counter.
REQ-012 SHALL have: timer_load_count  out  32  to counter.
REQ-013 SHALL have: timer_current_value  in  32  from counter.
REQ-014 SHALL have: timer_interrupt  in  1  from counter; high for one cycle per terminal count.
REQ-015 SHALL have: irq  out  1  masked interrupt to the interrupt controller.

Function
REQ-016 SHALL decode word offsets: 0x00 LOAD_COUNT RW; 0x04 CURRENT_VALUE RO; 0x08 CONTROL RW (bit0 enable, bit1 mode 1=user load, bit2 int_mask 1=masked, bits31:3 read 0); 0x0C EOI RO; 0x10 INT_STATUS RO; 0x14 RAW_INT_STATUS RO.
REQ-017 SHALL define setup = psel & !penable; access = psel & penable.
REQ-018 SHALL register prdata at the setup-phase clock edge from the addressed register; prdata holds through access; CURRENT_VALUE therefore sampled one cycle before access.
REQ-019 SHALL commit writes at the clock edge ending the access phase; no effect outside access.
REQ-020 SHALL drive pslverr=1 during access if paddr[1:0]!=0, offset >0x14, or write to an RO offset; such transfers change no state; error reads return prdata=0.
REQ-021 SHALL drive pslverr=0 outside access phase.
REQ-022 SHALL drive timer_enable, timer_mode, timer_load_count directly from CONTROL bit0, bit1, LOAD_COUNT.
REQ-023 SHALL set raw_status on a rising edge of timer_interrupt (registered previous value).
REQ-024 SHALL clear raw_status at the access-phase edge of a valid read of EOI; EOI read data 0.
REQ-025 SHALL give set priority over EOI clear when both occur in the same cycle (raw_status stays 1).
REQ-026 SHALL return raw_status in RAW_INT_STATUS bit0 and raw_status & !int_mask in INT_STATUS bit0; upper bits 0.
REQ-027 SHALL register irq = raw_status & !int_mask, updating one cycle after raw_status or mask change.
REQ-028 SHALL keep raw_status setting while masked; unmasking with status pending asserts irq next cycle.
REQ-029 SHALL keep raw_status independent of timer_enable; disabling timer does not clear it.

Reset
REQ-030 SHALL, on rstn low, asynchronously set LOAD_COUNT=0, CONTROL=0, raw_status=0, interrupt edge flop=0, irq=0, prdata=0, pslverr=0; pready=1.
REQ-031 SHALL abandon any in-flight transfer on reset with no register update.

Structure
REQ-032 SHALL place register offsets, CONTROL bit positions and data width in shared package timer_pkg, reused by the counter wrapper and software headers.
REQ-033 SHALL be a single module with no sub-modules; integration instantiates timer_regif beside the existing counter in a timer top.

Verification
REQ-034 SHALL cover reset: after rstn release, read CONTROL -> 0x0, LOAD_COUNT -> 0x0, irq=0, pslverr=0.
REQ-035 SHALL cover config: write LOAD_COUNT=0x10, CONTROL=0x3 -> timer_load_count=0x10, timer_enable=1, timer_mode=1 the cycle after access.
REQ-036 SHALL cover interrupt: pulse timer_interrupt one cycle -> RAW_INT_STATUS=1, irq=1 next cycle; read EOI -> prdata 0, irq=0 one cycle after.
REQ-037 SHALL cover collision: timer_interrupt edge in the EOI access cycle -> raw_status remains 1, irq stays 1.
REQ-038 SHALL cover masking: CONTROL=0x5, pulse interrupt -> RAW_INT_STATUS=1, INT_STATUS=0, irq=0; write CONTROL=0x1 -> irq=1.
REQ-039 SHALL cover errors: write 0x04, read 0x18, access 0x02 -> pslverr=1, registers unchanged, read prdata=0.
